seq_divider: RTL and testbench



---
 rtl/seq_div_pkg.sv | 27 ++
 rtl/seq_div_step.sv | 21 ++
 rtl/seq_divider.sv | 164 ++++++++++++++++
 tb/tb_seq_divider.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the seq_divider long-latency divide unit.
package seq_div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } div_state_t;

   // Widest operand the result record can carry; DIVN_W and DIVR_W must not exceed it.
   localparam int unsigned RES_MAX_W = 64;

   typedef struct packed {
      logic [RES_MAX_W-1:0] quotient;
      logic [RES_MAX_W-1:0] remainder;
      logic                 div_zero;
      logic                 overflow;
   } div_result_t;

   // Divide-by-zero quotient: 'width' ones, zero-extended to the record width.
   function automatic logic [RES_MAX_W-1:0] zero_div_quotient(input int unsigned width);
      return {RES_MAX_W{1'b1}} >> (RES_MAX_W - width);
   endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module seq_div_step #(
   parameter int unsigned DIVR_W = 32
) (
   input  logic [DIVR_W:0]   rem_in,
   input  logic              dvd_bit,
   input  logic [DIVR_W-1:0] divisor_mag,
   output logic [DIVR_W:0]   rem_out,
   output logic              quo_bit
);

   logic [DIVR_W+1:0] shifted;
   logic [DIVR_W+1:0] trial;

   // rem_in < divisor_mag always holds, so the MSB of trial is a true sign bit.
   assign shifted = {rem_in, dvd_bit};
   assign trial   = shifted - {2'b00, divisor_mag};
   assign quo_bit = ~trial[DIVR_W+1];
   assign rem_out = quo_bit ? trial[DIVR_W:0] : shifted[DIVR_W:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider with valid/ready handshakes, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour signed_op; otherwise every operation is unsigned.
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int unsigned DIVN_W = 32,
   parameter int unsigned DIVR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DIVN_W-1:0] dividend,
   input  logic [DIVR_W-1:0] divisor,
   input  logic              signed_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DIVN_W-1:0] quotient,
   output logic [DIVR_W-1:0] remainder,
   output logic              div_zero,
   output logic              overflow
);

   localparam int unsigned      CNT_W    = $clog2(DIVN_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVN_W - 1);

   div_state_t        state, state_nxt;
   div_result_t       res;
   logic [DIVN_W-1:0] dvd_q;  // dividend going in, quotient coming out
   logic [DIVR_W-1:0] dvs_q;
   logic [DIVR_W:0]   prem_q, prem_nxt;
   logic [CNT_W-1:0]  cnt_q;
   logic              qbit;
   logic [DIVN_W-1:0] q_fix;
   logic [DIVR_W-1:0] r_fix;
   logic              accept, is_zero_div, is_ovf;
   logic              unused_res;

   assign accept      = in_valid && in_ready;
   assign is_zero_div = (divisor == '0);

`ifdef DIV_SIGNED_EN
   logic sgn_q, q_neg, r_neg;
   assign is_ovf = signed_op && (dividend == {1'b1, {(DIVN_W-1){1'b0}}}) && (divisor == '1);
`else
   logic unused_signed_op;
   assign is_ovf           = 1'b0;
   assign unused_signed_op = signed_op;
`endif

   seq_div_step #(.DIVR_W(DIVR_W)) u_step (
      .rem_in      (prem_q),
      .dvd_bit     (dvd_q[DIVN_W-1]),
      .divisor_mag (dvs_q),
      .rem_out     (prem_nxt),
      .quo_bit     (qbit)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: default assignment first so no path through the case leaves state_nxt latched.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (is_zero_div || is_ovf) ? DONE : PREP;
         PREP:    state_nxt = CALC;
         CALC:    if (cnt_q == CNT_LAST) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // NOTE: operand/iteration registers need no reset: each is loaded on acceptance or in PREP before use.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (accept) begin
               dvd_q <= dividend;
               dvs_q <= divisor;
`ifdef DIV_SIGNED_EN
               sgn_q <= signed_op;
`endif
            end
         end
         PREP: begin
`ifdef DIV_SIGNED_EN
            dvd_q <= (sgn_q && dvd_q[DIVN_W-1]) ? -dvd_q : dvd_q;
            dvs_q <= (sgn_q && dvs_q[DIVR_W-1]) ? -dvs_q : dvs_q;
            q_neg <= sgn_q && (dvd_q[DIVN_W-1] ^ dvs_q[DIVR_W-1]);
            r_neg <= sgn_q && dvd_q[DIVN_W-1];
`endif
            prem_q <= '0;
            cnt_q  <= '0;
         end
         CALC: begin
            prem_q <= prem_nxt;
            dvd_q  <= {dvd_q[DIVN_W-2:0], qbit};
            cnt_q  <= cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
`ifdef DIV_SIGNED_EN
      q_fix = q_neg ? -dvd_q : dvd_q;
      r_fix = r_neg ? -prem_q[DIVR_W-1:0] : prem_q[DIVR_W-1:0];
`else
      q_fix = dvd_q;
      r_fix = prem_q[DIVR_W-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && is_zero_div) begin
                  res.quotient  <= zero_div_quotient(DIVN_W);
                  res.remainder <= RES_MAX_W'(dividend[DIVR_W-1:0]);
                  res.div_zero  <= 1'b1;
                  res.overflow  <= 1'b0;
               end else if (accept && is_ovf) begin
                  res.quotient  <= RES_MAX_W'(dividend);
                  res.remainder <= '0;
                  res.div_zero  <= 1'b0;
                  res.overflow  <= 1'b1;
               end
            end
            FIX: begin
               res.quotient  <= RES_MAX_W'(q_fix);
               res.remainder <= RES_MAX_W'(r_fix);
               res.div_zero  <= 1'b0;
               res.overflow  <= 1'b0;
            end
            DONE: begin
               if (out_ready) begin
                  res.div_zero <= 1'b0;
                  res.overflow <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient   = res.quotient[DIVN_W-1:0];
   assign remainder  = res.remainder[DIVR_W-1:0];
   assign div_zero   = res.div_zero;
   assign overflow   = res.overflow;
   assign unused_res = ^res;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at 32/32: directed table, corner sequences, random vs. arithmetic model.
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif
   localparam int NORM_LAT = 34;
   localparam int MAX_WAIT = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] dividend, divisor;
   logic        signed_op;
   logic        out_valid, out_ready;
   logic [31:0] quotient, remainder;
   logic        div_zero, overflow;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ov;
      logic [7:0]  lat;
   } vec_t;

   vec_t vecs[15];

   seq_divider #(.DIVN_W(32), .DIVR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .signed_op (signed_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] a, b, input logic s,
                               input logic [31:0] q, r, input logic dz, ov, input int lat);
      return '{a: a, b: b, s: s, q: q, r: r, dz: dz, ov: ov, lat: 8'(lat)};
   endfunction

   // Reference: plain 64-bit arithmetic; SV integer division truncates toward zero.
   function automatic void model(input logic [31:0] a, b, input logic s,
                                 output logic [31:0] q, r, output logic dz, ov);
      longint sa, sb;
      logic   en_s;
      en_s = s && SIGNED_EN;
      dz = 1'b0;
      ov = 1'b0;
      if (b == 32'd0) begin
         q = '1; r = a; dz = 1'b1;
      end else if (en_s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = '0; ov = 1'b1;
      end else if (en_s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic wait_ready(input string name);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < MAX_WAIT) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check({name, ".ready_timeout"}, 64'(in_ready), 64'd1);
   endtask

   task automatic run_op(input logic [31:0] a, b, input logic s, input logic [31:0] eq, er,
                         input logic edz, eov, input int elat, input string name);
      int lat;
      bit seen;
      wait_ready(name);
      dividend  = a;
      divisor   = b;
      signed_op = s;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < MAX_WAIT) begin
         @(posedge clk); #1;
         lat++;
         seen = out_valid;
      end
      check({name, ".latency"}, 64'(lat), 64'(elat));
      if (seen) begin
         check({name, ".quotient"}, 64'(quotient), 64'(eq));
         check({name, ".remainder"}, 64'(remainder), 64'(er));
         check({name, ".div_zero"}, 64'(div_zero), 64'(edz));
         check({name, ".overflow"}, 64'(overflow), 64'(eov));
         @(negedge clk) out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check({name, ".post_out_valid"}, 64'(out_valid), 64'd0);
         check({name, ".post_in_ready"}, 64'(in_ready), 64'd1);
      end
   endtask

   initial begin
      logic [31:0] a, b, eq, er;
      logic        s, edz, eov;
      int          mode, lat, seen_cnt;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0; signed_op = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check("reset.in_ready", 64'(in_ready), 64'd1);
      check("reset.out_valid", 64'(out_valid), 64'd0);
      check("reset.quotient", 64'(quotient), 64'd0);
      check("reset.remainder", 64'(remainder), 64'd0);
      check("reset.div_zero", 64'(div_zero), 64'd0);
      check("reset.overflow", 64'(overflow), 64'd0);

      vecs[0]  = mk(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, NORM_LAT);
      vecs[1]  = mk(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 1);
      vecs[2]  = SIGNED_EN ? mk(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, NORM_LAT)
                           : mk(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, NORM_LAT);
      vecs[3]  = SIGNED_EN ? mk(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, NORM_LAT)
                           : mk(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, 1'b0, NORM_LAT);
      vecs[4]  = SIGNED_EN ? mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1)
                           : mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b0, NORM_LAT);
      vecs[5]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b0, NORM_LAT);
      vecs[6]  = mk(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, NORM_LAT);
      vecs[7]  = mk(32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1);
      vecs[8]  = mk(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, NORM_LAT);
      vecs[9]  = SIGNED_EN ? mk(32'hFFFF_FFFA, 32'd3, 1'b1, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, NORM_LAT)
                           : mk(32'hFFFF_FFFA, 32'd3, 1'b1, 32'h5555_5553, 32'd1, 1'b0, 1'b0, NORM_LAT);
      vecs[10] = SIGNED_EN ? mk(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, NORM_LAT)
                           : mk(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd0, 32'hFFFF_FFF8, 1'b0, 1'b0, NORM_LAT);
      vecs[11] = SIGNED_EN ? mk(32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 32'd0, 1'b0, 1'b0, NORM_LAT)
                           : mk(32'h8000_0000, 32'd2, 1'b1, 32'h4000_0000, 32'd0, 1'b0, 1'b0, NORM_LAT);
      vecs[12] = mk(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 1);
      vecs[13] = mk(32'd6, 32'd6, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, NORM_LAT);
      vecs[14] = mk(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, 1'b0, NORM_LAT);

      for (int i = 0; i < 15; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov,
                int'(vecs[i].lat), $sformatf("vec%0d", i));

      // Backpressure: out_ready pulsed mid-calculation, then withheld for 5 cycles in DONE.
      wait_ready("bp");
      dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < MAX_WAIT) begin
         out_ready = (lat >= 3 && lat < 6);
         @(posedge clk); #1;
         lat++;
      end
      out_ready = 1'b0;
      check("bp.latency", 64'(lat), 64'(NORM_LAT));
      dividend = 32'd77; divisor = 32'd5; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp.hold%0d.out_valid", c), 64'(out_valid), 64'd1);
         check($sformatf("bp.hold%0d.in_ready", c), 64'(in_ready), 64'd0);
         check($sformatf("bp.hold%0d.quotient", c), 64'(quotient), 64'd333);
         check($sformatf("bp.hold%0d.remainder", c), 64'(remainder), 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp.after.in_ready", 64'(in_ready), 64'd1);
      check("bp.after.out_valid", 64'(out_valid), 64'd0);
      check("bp.after.quotient", 64'(quotient), 64'd333);

      // Reset in the middle of CALC drops the operation.
      wait_ready("rst_mid");
      dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check("rst_mid.in_ready", 64'(in_ready), 64'd1);
      check("rst_mid.out_valid", 64'(out_valid), 64'd0);
      check("rst_mid.quotient", 64'(quotient), 64'd0);
      seen_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid) seen_cnt++;
      end
      check("rst_mid.dropped", 64'(seen_cnt), 64'd0);
      run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, NORM_LAT, "rst_mid.next");

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 200; i++) begin
         a    = $urandom;
         s    = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 9);
         case (mode)
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 15));
            3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            4:       b = -32'($urandom_range(1, 15));
            5:       a = 32'h8000_0000 | 32'($urandom_range(0, 3));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         if (mode == 5) b = $urandom >> $urandom_range(0, 31);
         model(a, b, s, eq, er, edz, eov);
         run_op(a, b, s, eq, er, edz, eov, (edz || eov) ? 1 : NORM_LAT, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
